writeback_stage: RTL and testbench
==================================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; the ports are named as below.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low; 0 means reset is asserted.
REQ-004 SHALL have port valid_in, input, 1 bit: the MEM-stage instruction is valid.
REQ-005 SHALL have port flush_in, input, 1 bit: capture a bubble instead of the MEM-stage instruction.
REQ-006 SHALL have port regWrite_in, input, 1 bit: the instruction writes a register.
REQ-007 SHALL have port memToReg_in, input, 1 bit: 1 selects load data, 0 selects the ALU result.
REQ-008 SHALL have port loadType_in, input, 3 bits: load width and sign (encodings in REQ-020).
REQ-009 SHALL have port addrLow_in, input, 2 bits: byte offset of the load address.
REQ-010 SHALL have port destReg_in, input, 5 bits: destination register number.
REQ-011 SHALL have port aluResult_in, input, 32 bits: ALU result.
REQ-012 SHALL have port memData_in, input, 32 bits: aligned word read from data memory.
REQ-013 SHALL have port clrErr_in, input, 1 bit: clears the sticky alignment error.
REQ-014 SHALL have ports enable_out (1 bit), writeReg_out (5 bits) and writeData_out (32 bits), all outputs, forming the register-file write port.
REQ-015 SHALL have ports fwdValid_out (1 bit), fwdReg_out (5 bits) and fwdData_out (32 bits), all outputs, forming the forwarding source to EX.
REQ-016 SHALL have port alignErr_out, output, 1 bit: sticky misaligned-load flag.
REQ-017 SHALL have port retired_out, output, 32 bits: count of retired instructions.

Function
REQ-018 SHALL register all MEM-stage inputs on each rising clk edge into a single stage register; all outputs are driven from that register, giving one cycle of latency.
REQ-019 SHALL capture valid=0 when flush_in=1, regardless of valid_in; flush has priority.
REQ-020 SHALL use loadType encodings 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu; encodings 101-111 behave as lw.
REQ-021 SHALL select load bytes big-endian: byte offset 0 is memData[31:24] and halfword offset 0 is memData[31:16]; lh/lb sign-extend and lhu/lbu zero-extend to 32 bits.
REQ-022 SHALL flag a misaligned load when memToReg=1 and either the type is lw with addrLow!=00, or the type is lh/lhu with addrLow[0]=1.
REQ-023 SHALL compute writeData_out as the extended load data when memToReg=1, otherwise as aluResult.
REQ-024 SHALL assert enable_out = valid & regWrite & (destReg!=0) & !misaligned; writeReg_out = destReg.
REQ-025 SHALL drive fwdValid_out equal to enable_out, fwdReg_out equal to writeReg_out, and fwdData_out equal to writeData_out.
REQ-026 SHALL set alignErr_out on the clock edge after a valid misaligned instruction is held in the stage, and keep it set until clrErr_in=1 or reset; when set and clear coincide, set wins.
REQ-027 SHALL increment retired_out by 1 for each valid, non-misaligned instruction held in the stage (counted on the following edge), wrapping from FFFFFFFF to 0.
REQ-028 SHALL count an instruction with regWrite=0 or destReg=0 as retired, but SHALL NOT write it to the register file.
REQ-029 SHALL complete each valid instruction in exactly one cycle; there are no back-pressure inputs.

Reset
REQ-030 SHALL, while reset=0, immediately clear stage valid, enable_out, fwdValid_out, writeReg_out, writeData_out, fwdReg_out, fwdData_out, alignErr_out and retired_out to 0.
REQ-031 SHALL, when reset asserts mid-operation, drop the held instruction without writing it; the first capture occurs on the first rising edge with reset=1.

Structure
REQ-032 SHALL define the loadType encodings as named constants in the shared package mips_pkg, alongside the pipeline opcode constants.
REQ-033 SHALL implement byte/halfword selection and extension in a combinational sub-module load_extend, with inputs loadType, addrLow and word and outputs data and misaligned.

Verification
REQ-034 SHALL verify an ALU write: valid=1, regWrite=1, memToReg=0, dest=5, alu=0x12345678 -> the next cycle shows enable=1, writeReg=5, data=0x12345678, and retired increments by 1.
REQ-035 SHALL verify load extension: mem=0x80FF7F01 with lb off 0 -> 0xFFFFFF80; lbu off 1 -> 0x000000FF; lh off 2 -> 0x00007F01; lhu off 0 -> 0x000080FF.
REQ-036 SHALL verify misalignment: lw off 2 with dest=3 -> enable=0, alignErr=1 from the next edge and persisting; retired unchanged; clrErr=1 clears it.
REQ-037 SHALL verify the r0 and flush cases: dest=0 -> enable=0 and retired+1; flush=1 with valid=1 -> enable=0 and retired unchanged.
REQ-038 SHALL verify a mid-operation reset: assert reset=0 asynchronously between edges while enable=1 -> all outputs are 0 immediately, before the next clk edge.
REQ-039 SHALL verify counter wrap: preload retired to FFFFFFFF by force, then retire one instruction -> retired reads 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared pipeline constants: opcodes, load-type encodings and the WB stage register layout.
package mips_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_BEQ   = 6'h04,
    OP_ADDI  = 6'h08,
    OP_LB    = 6'h20,
    OP_LH    = 6'h21,
    OP_LW    = 6'h23,
    OP_LBU   = 6'h24,
    OP_LHU   = 6'h25,
    OP_SW    = 6'h2B
  } opcode_e;

  // Encodings 101-111 are not named and fall back to word behaviour.
  typedef enum logic [2:0] {
    LT_LW  = 3'b000,
    LT_LH  = 3'b001,
    LT_LHU = 3'b010,
    LT_LB  = 3'b011,
    LT_LBU = 3'b100
  } load_type_e;

  typedef struct packed {
    logic        valid;
    logic        regWrite;
    logic        memToReg;
    logic [2:0]  loadType;
    logic [1:0]  addrLow;
    logic [4:0]  destReg;
    logic [31:0] aluResult;
    logic [31:0] memData;
  } wb_stage_t;

endpackage

// File: rtl/load_extend.sv
// Big-endian byte/halfword extraction and sign/zero extension of a loaded word.
module load_extend
  import mips_pkg::*;
(
  input  logic [2:0]  loadType,
  input  logic [1:0]  addrLow,
  input  logic [31:0] word,
  output logic [31:0] data,
  output logic        misaligned
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Offset 0 is the most significant byte/halfword of the word.
  always_comb begin
    byteSel = word[31:24];
    case (addrLow)
      2'd0: byteSel = word[31:24];
      2'd1: byteSel = word[23:16];
      2'd2: byteSel = word[15:8];
      2'd3: byteSel = word[7:0];
      default: byteSel = word[31:24];
    endcase
    halfSel = addrLow[1] ? word[15:0] : word[31:16];
  end

  always_comb begin
    data       = word;
    misaligned = (addrLow != 2'b00);
    case (load_type_e'(loadType))
      LT_LH: begin
        data       = {{16{halfSel[15]}}, halfSel};
        misaligned = addrLow[0];
      end
      LT_LHU: begin
        data       = {16'h0000, halfSel};
        misaligned = addrLow[0];
      end
      LT_LB: begin
        data       = {{24{byteSel[7]}}, byteSel};
        misaligned = 1'b0;
      end
      LT_LBU: begin
        data       = {24'h000000, byteSel};
        misaligned = 1'b0;
      end
      default: begin
        data       = word;
        misaligned = (addrLow != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: registers the MEM-stage result, forms the register-file write and
// forwarding ports, and tracks sticky alignment errors and retired instructions.
module writeback_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        flush_in,
  input  logic        regWrite_in,
  input  logic        memToReg_in,
  input  logic [2:0]  loadType_in,
  input  logic [1:0]  addrLow_in,
  input  logic [4:0]  destReg_in,
  input  logic [31:0] aluResult_in,
  input  logic [31:0] memData_in,
  input  logic        clrErr_in,
  output logic        enable_out,
  output logic [4:0]  writeReg_out,
  output logic [31:0] writeData_out,
  output logic        fwdValid_out,
  output logic [4:0]  fwdReg_out,
  output logic [31:0] fwdData_out,
  output logic        alignErr_out,
  output logic [31:0] retired_out
);

  wb_stage_t   stage_q, stage_d;
  logic        alignErr_q, alignErr_d;
  logic [31:0] retired_q, retired_d;

  logic [31:0] loadData;
  logic        loadMisaligned;
  logic        misaligned;
  logic        enable;
  logic [31:0] writeData;

  always_comb begin
    stage_d           = '0;
    stage_d.valid     = valid_in & ~flush_in;
    stage_d.regWrite  = regWrite_in;
    stage_d.memToReg  = memToReg_in;
    stage_d.loadType  = loadType_in;
    stage_d.addrLow   = addrLow_in;
    stage_d.destReg   = destReg_in;
    stage_d.aluResult = aluResult_in;
    stage_d.memData   = memData_in;
  end

  load_extend u_load_extend (
    .loadType   (stage_q.loadType),
    .addrLow    (stage_q.addrLow),
    .word       (stage_q.memData),
    .data       (loadData),
    .misaligned (loadMisaligned)
  );

  // Alignment only matters when the result actually comes from memory.
  always_comb begin
    misaligned = stage_q.memToReg & loadMisaligned;
    writeData  = stage_q.memToReg ? loadData : stage_q.aluResult;
    enable     = stage_q.valid & stage_q.regWrite & (stage_q.destReg != 5'd0) & ~misaligned;
  end

  always_comb begin
    alignErr_d = alignErr_q;
    if (clrErr_in) begin
      alignErr_d = 1'b0;
    end
    if (stage_q.valid && misaligned) begin
      alignErr_d = 1'b1;
    end
    retired_d = retired_q;
    if (stage_q.valid && !misaligned) begin
      retired_d = retired_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_q    <= '0;
      alignErr_q <= 1'b0;
      retired_q  <= 32'd0;
    end else begin
      stage_q    <= stage_d;
      alignErr_q <= alignErr_d;
      retired_q  <= retired_d;
    end
  end

  // A cleared stage register yields all-zero write/forward ports during reset.
  assign enable_out    = enable;
  assign writeReg_out  = stage_q.destReg;
  assign writeData_out = writeData;
  assign fwdValid_out  = enable;
  assign fwdReg_out    = stage_q.destReg;
  assign fwdData_out   = writeData;
  assign alignErr_out  = alignErr_q;
  assign retired_out   = retired_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage with hand-computed expectations.
module tb_writeback_stage;

  logic        clk;
  logic        reset;
  logic        valid_in;
  logic        flush_in;
  logic        regWrite_in;
  logic        memToReg_in;
  logic [2:0]  loadType_in;
  logic [1:0]  addrLow_in;
  logic [4:0]  destReg_in;
  logic [31:0] aluResult_in;
  logic [31:0] memData_in;
  logic        clrErr_in;
  logic        enable_out;
  logic [4:0]  writeReg_out;
  logic [31:0] writeData_out;
  logic        fwdValid_out;
  logic [4:0]  fwdReg_out;
  logic [31:0] fwdData_out;
  logic        alignErr_out;
  logic [31:0] retired_out;

  int checkCount = 0;
  int passCount  = 0;

  writeback_stage dut (
    .clk           (clk),
    .reset         (reset),
    .valid_in      (valid_in),
    .flush_in      (flush_in),
    .regWrite_in   (regWrite_in),
    .memToReg_in   (memToReg_in),
    .loadType_in   (loadType_in),
    .addrLow_in    (addrLow_in),
    .destReg_in    (destReg_in),
    .aluResult_in  (aluResult_in),
    .memData_in    (memData_in),
    .clrErr_in     (clrErr_in),
    .enable_out    (enable_out),
    .writeReg_out  (writeReg_out),
    .writeData_out (writeData_out),
    .fwdValid_out  (fwdValid_out),
    .fwdReg_out    (fwdReg_out),
    .fwdData_out   (fwdData_out),
    .alignErr_out  (alignErr_out),
    .retired_out   (retired_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  task automatic clearInputs();
    valid_in     = 1'b0;
    flush_in     = 1'b0;
    regWrite_in  = 1'b0;
    memToReg_in  = 1'b0;
    loadType_in  = 3'b000;
    addrLow_in   = 2'b00;
    destReg_in   = 5'd0;
    aluResult_in = 32'd0;
    memData_in   = 32'd0;
    clrErr_in    = 1'b0;
  endtask

  // Drive one MEM-stage instruction at the falling edge, then sample 1 after capture.
  task automatic applyStimulus(input logic v, input logic fl, input logic rw, input logic m2r,
                               input logic [2:0] lt, input logic [1:0] al, input logic [4:0] rd,
                               input logic [31:0] alu, input logic [31:0] mem, input logic clr);
    @(negedge clk);
    valid_in     = v;
    flush_in     = fl;
    regWrite_in  = rw;
    memToReg_in  = m2r;
    loadType_in  = lt;
    addrLow_in   = al;
    destReg_in   = rd;
    aluResult_in = alu;
    memData_in   = mem;
    clrErr_in    = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle(input logic clr);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 5'd0, 32'd0, 32'd0, clr);
  endtask

  initial begin
    clearInputs();
    reset = 1'b0;
    #1;
    checkOutput("reset_enable", {31'd0, enable_out}, 32'd0);
    checkOutput("reset_data", writeData_out, 32'd0);
    checkOutput("reset_retired", retired_out, 32'd0);
    checkOutput("reset_alignErr", {31'd0, alignErr_out}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // ALU write to r5
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 2'b00, 5'd5, 32'h12345678, 32'h0, 1'b0);
    checkOutput("alu_enable", {31'd0, enable_out}, 32'd1);
    checkOutput("alu_writeReg", {27'd0, writeReg_out}, 32'd5);
    checkOutput("alu_data", writeData_out, 32'h12345678);
    checkOutput("alu_fwdValid", {31'd0, fwdValid_out}, 32'd1);
    checkOutput("alu_fwdReg", {27'd0, fwdReg_out}, 32'd5);
    checkOutput("alu_fwdData", fwdData_out, 32'h12345678);
    checkOutput("alu_retired_before", retired_out, 32'd0);

    // Load extension of 0x80FF7F01
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 3'b011, 2'd0, 5'd7, 32'hDEADBEEF, 32'h80FF7F01, 1'b0);
    checkOutput("alu_retired_after", retired_out, 32'd1);
    checkOutput("lb_off0", writeData_out, 32'hFFFFFF80);
    checkOutput("lb_enable", {31'd0, enable_out}, 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 3'b100, 2'd1, 5'd8, 32'hDEADBEEF, 32'h80FF7F01, 1'b0);
    checkOutput("lbu_off1", writeData_out, 32'h000000FF);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 3'b001, 2'd2, 5'd9, 32'hDEADBEEF, 32'h80FF7F01, 1'b0);
    checkOutput("lh_off2", writeData_out, 32'h00007F01);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 2'd0, 5'd10, 32'hDEADBEEF, 32'h80FF7F01, 1'b0);
    checkOutput("lhu_off0", writeData_out, 32'h000080FF);
    checkOutput("loads_retired", retired_out, 32'd4);

    // Misaligned lw to r3
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 3'b000, 2'd2, 5'd3, 32'h0, 32'h11223344, 1'b0);
    checkOutput("mis_enable", {31'd0, enable_out}, 32'd0);
    checkOutput("mis_alignErr_pre", {31'd0, alignErr_out}, 32'd0);
    idleCycle(1'b0);
    checkOutput("mis_alignErr_set", {31'd0, alignErr_out}, 32'd1);
    checkOutput("mis_retired", retired_out, 32'd5);
    idleCycle(1'b0);
    checkOutput("mis_alignErr_hold", {31'd0, alignErr_out}, 32'd1);
    idleCycle(1'b1);
    checkOutput("mis_alignErr_clr", {31'd0, alignErr_out}, 32'd0);

    // Misaligned lh with clear coinciding with set: set wins
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 3'b001, 2'd1, 5'd4, 32'h0, 32'h11223344, 1'b0);
    checkOutput("lh_mis_enable", {31'd0, enable_out}, 32'd0);
    idleCycle(1'b1);
    checkOutput("setwins_alignErr", {31'd0, alignErr_out}, 32'd1);
    idleCycle(1'b1);
    checkOutput("setwins_cleared", {31'd0, alignErr_out}, 32'd0);
    checkOutput("lh_mis_retired", retired_out, 32'd5);

    // Write to r0: retired but not written
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 2'd0, 5'd0, 32'hAAAA5555, 32'h0, 1'b0);
    checkOutput("r0_enable", {31'd0, enable_out}, 32'd0);
    idleCycle(1'b0);
    checkOutput("r0_retired", retired_out, 32'd6);

    // Flush overrides valid
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 2'd0, 5'd6, 32'h55555555, 32'h0, 1'b0);
    checkOutput("flush_enable", {31'd0, enable_out}, 32'd0);
    checkOutput("flush_fwdValid", {31'd0, fwdValid_out}, 32'd0);
    idleCycle(1'b0);
    checkOutput("flush_retired", retired_out, 32'd6);

    // regWrite=0: retired but not written
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 2'd0, 5'd9, 32'h01010101, 32'h0, 1'b0);
    checkOutput("nowrite_enable", {31'd0, enable_out}, 32'd0);
    idleCycle(1'b0);
    checkOutput("nowrite_retired", retired_out, 32'd7);

    // Asynchronous reset mid-operation
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 2'd0, 5'd11, 32'hCAFEF00D, 32'h0, 1'b0);
    checkOutput("pre_reset_enable", {31'd0, enable_out}, 32'd1);
    #2;
    reset = 1'b0;
    clearInputs();
    #1;
    checkOutput("async_enable", {31'd0, enable_out}, 32'd0);
    checkOutput("async_fwdValid", {31'd0, fwdValid_out}, 32'd0);
    checkOutput("async_writeReg", {27'd0, writeReg_out}, 32'd0);
    checkOutput("async_data", writeData_out, 32'd0);
    checkOutput("async_fwdData", fwdData_out, 32'd0);
    checkOutput("async_retired", retired_out, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idleCycle(1'b0);
    checkOutput("post_reset_retired", retired_out, 32'd0);

    // Counter wrap
    @(negedge clk);
    force dut.retired_q = 32'hFFFFFFFF;
    #1;
    release dut.retired_q;
    #1;
    checkOutput("wrap_preload", retired_out, 32'hFFFFFFFF);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 2'd0, 5'd12, 32'h00000042, 32'h0, 1'b0);
    checkOutput("wrap_hold", retired_out, 32'hFFFFFFFF);
    idleCycle(1'b0);
    checkOutput("wrap_zero", retired_out, 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
